// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the run/single-step front panel: FSM encodings and the
// default debounce interval used by the front-panel inputs.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

  // 10 ms at 100 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/step_ctrl_debounce.sv
// Two-flop synchronizer plus counter debouncer for a raw mechanical input, with a
// single-cycle pulse on each rising edge of the debounced level.
module step_ctrl_debounce
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q;
  logic            rise_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      // Any return to the stable level restarts the qualification window.
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        stable_q <= sync2_q;
        rise_q   <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign dout = stable_q;
  assign rise = rise_q;

endmodule

// File: rtl/step_ctrl.sv
// Run/single-step controller: turns divider ticks, a step button and a run switch
// into single-cycle processor enables, and parks the core on a halt request.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned STEP_CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_div,
  input  logic                  step_btn,
  input  logic                  run_sw,
  input  logic                  halt_req,
  output logic                  div_en,
  output logic                  proc_en,
  output logic [1:0]            state,
  output logic [STEP_CNT_W-1:0] step_count
);

  logic                  run_db, run_rise;
  logic                  step_db, step_press;
  logic                  tick;
  state_e                state_q;
  logic                  div_en_q, proc_en_q;
  logic                  clk_div_prev_q, run_db_prev_q;
  logic [STEP_CNT_W-1:0] step_count_q;

  step_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_run (
    .clk (clk),
    .rst (rst),
    .din (run_sw),
    .dout(run_db),
    .rise(run_rise)
  );

  step_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_step (
    .clk (clk),
    .rst (rst),
    .din (step_btn),
    .dout(step_db),
    .rise(step_press)
  );

  // clk_div is a data signal from the same domain; only its rising edge matters.
  assign tick = clk_div & ~clk_div_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      div_en_q       <= 1'b0;
      proc_en_q      <= 1'b0;
      clk_div_prev_q <= 1'b0;
      run_db_prev_q  <= 1'b0;
      step_count_q   <= '0;
    end else begin
      clk_div_prev_q <= clk_div;
      run_db_prev_q  <= run_db;
      proc_en_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (run_db) begin
            state_q  <= ST_RUN;
            div_en_q <= 1'b1;
          end else if (step_press) begin
            state_q  <= ST_STEP;
            div_en_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            state_q  <= ST_HALTED;
            div_en_q <= 1'b0;
          end else if (!run_db) begin
            state_q  <= ST_IDLE;
            div_en_q <= 1'b0;
          end else if (tick) begin
            proc_en_q    <= 1'b1;
            step_count_q <= step_count_q + STEP_CNT_W'(1);
          end
        end
        ST_STEP: begin
          if (halt_req) begin
            state_q  <= ST_HALTED;
            div_en_q <= 1'b0;
          end else if (tick) begin
            proc_en_q    <= 1'b1;
            step_count_q <= step_count_q + STEP_CNT_W'(1);
            state_q      <= ST_IDLE;
            div_en_q     <= 1'b0;
          end
        end
        ST_HALTED: begin
          // Leaving requires the operator to flip run off.
          if (run_db_prev_q && !run_db) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          div_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign state      = state_q;
  assign div_en     = div_en_q;
  assign proc_en    = proc_en_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with a short debounce window and a 2-bit step counter.
module tb_step_ctrl;
  import step_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       clk_div;
  logic       step_btn;
  logic       run_sw;
  logic       halt_req;
  logic       div_en;
  logic       proc_en;
  logic [1:0] state;
  logic [1:0] step_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   div_on;
  int   div_ph;
  logic cd_p, cd_pp;

  step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .STEP_CNT_W     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_div   (clk_div),
    .step_btn  (step_btn),
    .run_sw    (run_sw),
    .halt_req  (halt_req),
    .div_en    (div_en),
    .proc_en   (proc_en),
    .state     (state),
    .step_count(step_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One clock: clk_div advances just after the rising edge, sampling is at the falling edge.
  task automatic cyc();
    cd_pp = cd_p;
    cd_p  = clk_div;
    @(posedge clk);
    #1;
    if (div_on) begin
      clk_div = (div_ph < 10);
      div_ph  = (div_ph + 1) % 20;
    end else begin
      clk_div = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    div_on   = 1'b0;
    div_ph   = 0;
    clk_div  = 1'b0;
    cd_p     = 1'b0;
    cd_pp    = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0; clk_div = 1'b0;
    #2;
    n_checks++;
    if (state !== ST_IDLE || proc_en !== 1'b0 || div_en !== 1'b0 || step_count !== 2'd0)
      $display("FAIL reset_async: state=%b proc_en=%b div_en=%b cnt=%0d, want 00/0/0/0",
               state, proc_en, div_en, step_count);
    else n_pass++;
    do_reset();
    div_on = 1'b1;
    div_ph = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      n_checks++;
      if (state !== ST_IDLE || proc_en !== 1'b0 || div_en !== 1'b0 || step_count !== 2'd0)
        $display("FAIL reset_idle cyc %0d: state=%b proc_en=%b div_en=%b cnt=%0d, want 00/0/0/0",
                 i, state, proc_en, div_en, step_count);
      else n_pass++;
    end
  endtask

  task automatic test_run();
    int pulses;
    do_reset();
    run_sw = 1'b1;
    repeat (6) cyc();
    n_checks++;
    if (state !== ST_IDLE) $display("FAIL run_early: state=%b want 00", state);
    else n_pass++;
    cyc();
    n_checks++;
    if (state !== ST_RUN || div_en !== 1'b1)
      $display("FAIL run_enter: state=%b div_en=%b want 01/1", state, div_en);
    else n_pass++;
    div_on = 1'b1;
    div_ph = 0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      n_checks++;
      if (proc_en !== (cd_p & ~cd_pp))
        $display("FAIL run_pulse cyc %0d: proc_en=%b want %b", i, proc_en, cd_p & ~cd_pp);
      else n_pass++;
      if (proc_en === 1'b1) begin
        pulses++;
        n_checks++;
        if (step_count !== 2'(pulses))
          $display("FAIL run_count_same_cycle: cnt=%0d want %0d", step_count, pulses);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 3 || step_count !== 2'd3 || div_en !== 1'b1)
      $display("FAIL run_total: pulses=%0d cnt=%0d div_en=%b want 3/3/1",
               pulses, step_count, div_en);
    else n_pass++;
  endtask

  task automatic test_step_bounce();
    logic       pat [14];
    logic [1:0] prev_st;
    int         entries, pulses;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    entries = 0;
    pulses  = 0;
    prev_st = state;
    for (int i = 0; i < 24; i++) begin
      step_btn = (i < 14) ? pat[i] : 1'b0;
      cyc();
      if (state == ST_STEP && prev_st != ST_STEP) entries++;
      prev_st = state;
    end
    n_checks++;
    if (state !== ST_STEP || div_en !== 1'b1 || proc_en !== 1'b0 || step_count !== 2'd0)
      $display("FAIL step_wait: state=%b div_en=%b proc_en=%b cnt=%0d want 10/1/0/0",
               state, div_en, proc_en, step_count);
    else n_pass++;
    div_on = 1'b1;
    div_ph = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (proc_en === 1'b1) pulses++;
      if (state == ST_STEP && prev_st != ST_STEP) entries++;
      prev_st = state;
    end
    n_checks++;
    if (entries != 1 || pulses != 1)
      $display("FAIL step_once: entries=%0d pulses=%0d want 1/1", entries, pulses);
    else n_pass++;
    n_checks++;
    if (state !== ST_IDLE || step_count !== 2'd1 || div_en !== 1'b0)
      $display("FAIL step_return: state=%b cnt=%0d div_en=%b want 00/1/0",
               state, step_count, div_en);
    else n_pass++;
  endtask

  task automatic test_halt();
    int pulses;
    bit ok;
    do_reset();
    run_sw = 1'b1;
    repeat (7) cyc();
    n_checks++;
    if (state !== ST_RUN) $display("FAIL halt_pre_run: state=%b want 01", state);
    else n_pass++;
    // halt_req rises together with clk_div so the FSM sees both on the same edge.
    cd_pp = cd_p;
    cd_p  = clk_div;
    @(posedge clk);
    #1;
    clk_div  = 1'b1;
    halt_req = 1'b1;
    div_on   = 1'b1;
    div_ph   = 1;
    @(negedge clk);
    cyc();
    n_checks++;
    if (state !== ST_HALTED || proc_en !== 1'b0 || div_en !== 1'b0)
      $display("FAIL halt_enter: state=%b proc_en=%b div_en=%b want 11/0/0",
               state, proc_en, div_en);
    else n_pass++;
    step_btn = 1'b1;
    pulses   = 0;
    repeat (30) begin
      cyc();
      if (proc_en === 1'b1) pulses++;
    end
    n_checks++;
    if (state !== ST_HALTED || pulses != 0 || step_count !== 2'd0)
      $display("FAIL halt_hold: state=%b pulses=%0d cnt=%0d want 11/0/0",
               state, pulses, step_count);
    else n_pass++;
    step_btn = 1'b0;
    halt_req = 1'b0;
    run_sw   = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc();
      if (proc_en === 1'b1) pulses++;
      if (state == ST_IDLE) ok = 1'b1;
    end
    n_checks++;
    if (!ok || pulses != 0)
      $display("FAIL halt_exit: state=%b pulses=%0d want 00/0", state, pulses);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [1:0] seq [5];
    int         k;
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    run_sw = 1'b1;
    repeat (7) cyc();
    div_on = 1'b1;
    div_ph = 0;
    k = 0;
    repeat (100) begin
      cyc();
      if (proc_en === 1'b1) begin
        if (k < 5) begin
          n_checks++;
          if (step_count !== seq[k])
            $display("FAIL wrap_seq %0d: cnt=%0d want %0d", k, step_count, seq[k]);
          else n_pass++;
        end
        k++;
      end
    end
    n_checks++;
    if (k != 5) $display("FAIL wrap_pulses: got %0d want 5", k);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int pulses;
    bit found;
    do_reset();
    run_sw = 1'b1;
    repeat (7) cyc();
    div_on = 1'b1;
    div_ph = 0;
    // Stop on the sample where clk_div first reads high: proc_en is due next edge.
    repeat (21) cyc();
    n_checks++;
    if (step_count !== 2'd1 || clk_div !== 1'b1 || state !== ST_RUN)
      $display("FAIL mid_pre: cnt=%0d clk_div=%b state=%b want 1/1/01",
               step_count, clk_div, state);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (proc_en !== 1'b0 || state !== ST_IDLE || step_count !== 2'd0 || div_en !== 1'b0)
      $display("FAIL mid_async: proc_en=%b state=%b cnt=%0d div_en=%b want 0/00/0/0",
               proc_en, state, step_count, div_en);
    else n_pass++;
    cyc();
    n_checks++;
    if (proc_en !== 1'b0) $display("FAIL mid_held: proc_en=%b want 0", proc_en);
    else n_pass++;
    rst    = 1'b1;
    pulses = 0;
    repeat (10) begin
      cyc();
      if (proc_en === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL mid_no_stale: pulses=%0d want 0", pulses);
    else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (proc_en === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || state !== ST_RUN || step_count !== 2'd1)
      $display("FAIL mid_resume: found=%b state=%b cnt=%0d want 1/01/1",
               found, state, step_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_step_bounce();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
